clt_grng_accum: RTL and testbench
=================================

CLT_GRNG_ACCUM -- requirements
Module: clt_grng_accum

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 16: width of the LFSR word consumed, range 3..32.
REQ-002 The block SHALL have parameter NUM_ACC, default 8: number of LFSR words summed per output sample, even, range 2..256.
REQ-003 The block SHALL derive localparam OUT_W = $clog2(NUM_BITS*NUM_ACC)+1, the signed sample width.
REQ-004 The block SHALL have port i_Clk  input  1  single clock, all state on its rising edge.
REQ-005 The block SHALL have port i_Rst_L  input  1  reset, asynchronous assertion, active-low.
REQ-006 The block SHALL have port i_Start  input  1  single-cycle pulse that starts accumulation from IDLE.
REQ-007 The block SHALL have port i_Continuous  input  1  when 1, start the next sample automatically after each output handshake.
REQ-008 The block SHALL have port o_LFSR_Enable  output  1  request/advance strobe to the upstream LFSR.
REQ-009 The block SHALL have port i_LFSR_Data  input  NUM_BITS  current LFSR word.
REQ-010 The block SHALL have port i_LFSR_Valid  input  1  i_LFSR_Data is usable this cycle.
REQ-011 The block SHALL have port o_Sample  output  OUT_W  signed, zero-centred approximate Gaussian sample.
REQ-012 The block SHALL have port o_Sample_Valid  output  1  o_Sample holds a completed sample.
REQ-013 The block SHALL have port i_Sample_Ready  input  1  downstream accepts o_Sample.
REQ-014 The block SHALL have port o_Busy  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL implement the FSM states IDLE, ACCUM and HOLD.
REQ-016 In IDLE, i_Start=1 SHALL clear the accumulator and word counter and move the FSM to ACCUM on the next edge.
REQ-017 In ACCUM, o_LFSR_Enable SHALL be 1 combinationally; in IDLE and HOLD it SHALL be 0.
REQ-018 A word SHALL be accepted on an edge where state=ACCUM, o_LFSR_Enable=1 and i_LFSR_Valid=1; the accumulator then adds popcount(i_LFSR_Data) (0..NUM_BITS) and the counter increments.
REQ-019 ACCUM with i_LFSR_Valid=0 SHALL hold the accumulator and counter unchanged; gaps of any length are legal.
REQ-020 On acceptance of word NUM_ACC, the FSM SHALL enter HOLD and register o_Sample = sum - NUM_BITS*NUM_ACC/2, with o_Sample_Valid=1 in the following cycle (latency: 1 cycle after the last accepted word).
REQ-021 The accumulator SHALL be unsigned with width $clog2(NUM_BITS*NUM_ACC+1) and SHALL never overflow; the offset subtraction SHALL be exact in OUT_W-bit two's complement.
REQ-022 In HOLD, o_Sample and o_Sample_Valid SHALL stay stable until a handshake (o_Sample_Valid=1 and i_Sample_Ready=1 on the same edge).
REQ-023 On a handshake with i_Continuous=1, the FSM SHALL clear accumulator and counter and enter ACCUM; with i_Continuous=0 it SHALL enter IDLE.
REQ-024 o_Sample_Valid SHALL fall on the edge of the handshake; o_Sample SHALL retain its last value until overwritten.
REQ-025 i_Start SHALL be ignored in ACCUM and HOLD.
REQ-026 i_Sample_Ready SHALL be ignored outside HOLD.
REQ-027 i_Continuous SHALL be sampled only at the handshake edge.

Reset
REQ-028 i_Rst_L=0 SHALL asynchronously force state=IDLE, accumulator=0, counter=0, o_Sample=0 and o_Sample_Valid=0, and so o_Busy=0 and o_LFSR_Enable=0.
REQ-029 Reset asserted mid-ACCUM or mid-HOLD SHALL discard the partial or held sample; after release, the block SHALL wait for i_Start.

Verification
REQ-030 The bench SHALL cover: defaults, i_LFSR_Data=16'hFFFF constant valid, i_Start pulse -> after 8 accepted words, o_Sample_Valid=1 with o_Sample=+64 (8'h40).
REQ-031 The bench SHALL cover: data 16'h0000 -> o_Sample=-64 (8'hC0); data alternating 16'hAAAA/16'h0F0F -> o_Sample=0.
REQ-032 The bench SHALL cover: i_LFSR_Valid low every other cycle -> sample is still the sum of exactly 8 valid words, and o_LFSR_Enable stays high throughout ACCUM.
REQ-033 The bench SHALL cover: i_Sample_Ready held low 20 cycles in HOLD -> o_Sample stable, o_LFSR_Enable=0, no words consumed; ready=1 -> valid drops on the next edge.
REQ-034 The bench SHALL cover: i_Continuous=1 with ready always 1 -> back-to-back samples, one every 9 cycles with valid data, no lost or duplicate words.
REQ-035 The bench SHALL cover: i_Rst_L pulsed low after 5 accepted words -> all outputs 0 immediately; i_Start afterwards -> a full 8-word sample with no carry-over.

Source files
------------

// File: rtl/clt_grng_accum.sv
// Central-limit Gaussian sample generator: sums the popcount of NUM_ACC LFSR words, then removes the mean.
// Latency: o_Sample_Valid rises 1 cycle after the last accepted word; a ready-on-arrival sample occupies HOLD for one cycle.
// Backpressure: HOLD keeps the sample and stops LFSR requests until o_Sample_Valid and i_Sample_Ready meet on an edge.
module clt_grng_accum #(
    parameter int NUM_BITS = 16,
    parameter int NUM_ACC  = 8
) (
    input  logic                                   i_Clk,
    input  logic                                   i_Rst_L,
    input  logic                                   i_Start,
    input  logic                                   i_Continuous,
    output logic                                   o_LFSR_Enable,
    input  logic [NUM_BITS-1:0]                    i_LFSR_Data,
    input  logic                                   i_LFSR_Valid,
    output logic [$clog2(NUM_BITS*NUM_ACC)+1-1:0]  o_Sample,
    output logic                                   o_Sample_Valid,
    input  logic                                   i_Sample_Ready,
    output logic                                   o_Busy
);

    localparam int OUT_W  = $clog2(NUM_BITS*NUM_ACC) + 1;
    localparam int ACC_W  = $clog2(NUM_BITS*NUM_ACC + 1);
    localparam int CNT_W  = $clog2(NUM_ACC + 1);
    localparam int OFFSET = NUM_BITS * NUM_ACC / 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc_next;

    function automatic logic [ACC_W-1:0] popcount(input logic [NUM_BITS-1:0] d);
        logic [ACC_W-1:0] pc;
        pc = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            pc = pc + ACC_W'(d[i]);
        end
        return pc;
    endfunction

    // The accumulator is sized for the all-ones case, so this add cannot wrap.
    assign acc_next      = acc + popcount(i_LFSR_Data);
    assign o_LFSR_Enable = (state == S_ACCUM);
    assign o_Busy        = (state != S_IDLE);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state          <= S_IDLE;
            acc            <= '0;
            cnt            <= '0;
            o_Sample       <= '0;
            o_Sample_Valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_Start) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (i_LFSR_Valid) begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(NUM_ACC - 1)) begin
                            o_Sample       <= OUT_W'(acc_next) - OUT_W'(OFFSET);
                            o_Sample_Valid <= 1'b1;
                            state          <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (i_Sample_Ready) begin
                        o_Sample_Valid <= 1'b0;
                        if (i_Continuous) begin
                            acc   <= '0;
                            cnt   <= '0;
                            state <= S_ACCUM;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clt_grng_accum.sv
// Directed bench for clt_grng_accum at default parameters (16-bit words, 8 per sample, 8-bit sample).
module tb_clt_grng_accum;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        cont;
    logic        lfsr_en;
    logic [15:0] lfsr_data;
    logic        lfsr_vld;
    logic [7:0]  sample;
    logic        sample_vld;
    logic        sample_rdy;
    logic        busy;

    int checks = 0;
    int errors = 0;

    clt_grng_accum dut (
        .i_Clk          (clk),
        .i_Rst_L        (rst_n),
        .i_Start        (start),
        .i_Continuous   (cont),
        .o_LFSR_Enable  (lfsr_en),
        .i_LFSR_Data    (lfsr_data),
        .i_LFSR_Valid   (lfsr_vld),
        .o_Sample       (sample),
        .o_Sample_Valid (sample_vld),
        .i_Sample_Ready (sample_rdy),
        .o_Busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feed n accepted words alternating a/b; with gaps, an invalid all-ones word precedes each one.
    task automatic feed(input logic [15:0] a, input logic [15:0] b, input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                lfsr_vld  = 1'b0;
                lfsr_data = 16'hFFFF;
                check("gap_enable", lfsr_en, 1);
                tick();
                check("gap_no_valid", sample_vld, 0);
            end
            lfsr_vld  = 1'b1;
            lfsr_data = (k % 2 == 0) ? a : b;
            check("accum_enable", lfsr_en, 1);
            tick();
        end
        lfsr_vld = 1'b0;
    endtask

    function automatic int word_pop(input int w);
        return (w * 3) % 17;
    endfunction

    function automatic logic [15:0] word_data(input int w);
        logic [31:0] m;
        m = (32'd1 << word_pop(w)) - 32'd1;
        return m[15:0];
    endfunction

    function automatic logic [7:0] cont_expect(input int j);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) s += word_pop(8 * j + i);
        return 8'(s - 64);
    endfunction

    initial begin
        int w;
        int nsamp;
        int last_cyc;
        bit acc_now;

        rst_n = 1'b0; start = 1'b0; cont = 1'b0; lfsr_data = '0; lfsr_vld = 1'b0; sample_rdy = 1'b0;
        repeat (3) tick();
        check("rst_sample", sample, 0);
        check("rst_valid", sample_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_enable", lfsr_en, 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // All-ones words give +64, then stall 20 cycles in HOLD.
        pulse_start();
        check("start_busy", busy, 1);
        check("start_enable", lfsr_en, 1);
        feed(16'hFFFF, 16'hFFFF, 7, 0);
        check("ffff_not_yet", sample_vld, 0);
        feed(16'hFFFF, 16'hFFFF, 1, 0);
        check("ffff_valid", sample_vld, 1);
        check("ffff_sample", sample, 8'h40);
        lfsr_vld = 1'b1; lfsr_data = 16'h0000; start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("hold_sample", sample, 8'h40);
            check("hold_valid", sample_vld, 1);
            check("hold_enable", lfsr_en, 0);
        end
        start = 1'b0; lfsr_vld = 1'b0;
        sample_rdy = 1'b1;
        tick();
        check("hs_valid_drop", sample_vld, 0);
        check("hs_idle", busy, 0);
        check("hs_retain", sample, 8'h40);
        sample_rdy = 1'b0;
        tick();
        check("idle_stays", busy, 0);

        // All-zeros words give -64.
        pulse_start();
        feed(16'h0000, 16'h0000, 8, 0);
        check("zero_valid", sample_vld, 1);
        check("zero_sample", sample, 8'hC0);
        sample_rdy = 1'b1; tick(); sample_rdy = 1'b0;

        // Alternating patterns of weight 8 give 0.
        pulse_start();
        feed(16'hAAAA, 16'h0F0F, 8, 0);
        check("alt_valid", sample_vld, 1);
        check("alt_sample", sample, 8'h00);
        sample_rdy = 1'b1; tick(); sample_rdy = 1'b0;

        // Gaps every other cycle: only the eight weight-1 words count (8 - 64 = -56).
        pulse_start();
        feed(16'h0001, 16'h8000, 8, 1);
        check("gap_valid", sample_vld, 1);
        check("gap_sample", sample, 8'hC8);
        sample_rdy = 1'b1; tick(); sample_rdy = 1'b0;
        check("gap_idle", busy, 0);

        // Continuous mode: words advance only when consumed; samples every 9 cycles.
        cont = 1'b1; sample_rdy = 1'b1; lfsr_vld = 1'b1;
        w = 0; nsamp = 0; last_cyc = 0;
        lfsr_data = word_data(0);
        pulse_start();
        start = 1'b1;
        for (int c = 1; c < 60 && nsamp < 3; c++) begin
            acc_now = lfsr_en;
            tick();
            if (acc_now) w++;
            lfsr_data = word_data(w);
            if (sample_vld) begin
                check("cont_sample", sample, cont_expect(nsamp));
                if (nsamp > 0) check("cont_period", c - last_cyc, 9);
                last_cyc = c;
                nsamp++;
                if (nsamp == 3) begin
                    cont  = 1'b0;
                    start = 1'b0;
                end
            end
        end
        check("cont_count", nsamp, 3);
        check("cont_words", w, 24);
        tick();
        check("cont_end_idle", busy, 0);
        check("cont_end_valid", sample_vld, 0);
        sample_rdy = 1'b0; lfsr_vld = 1'b0;

        // Reset after 5 words discards the partial sum.
        pulse_start();
        feed(16'hFFFF, 16'hFFFF, 5, 0);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_enable", lfsr_en, 0);
        check("mrst_valid", sample_vld, 0);
        check("mrst_sample", sample, 0);
        #2;
        rst_n = 1'b1;
        lfsr_vld = 1'b1; lfsr_data = 16'hFFFF;
        repeat (3) tick();
        check("mrst_wait_busy", busy, 0);
        check("mrst_wait_enable", lfsr_en, 0);
        lfsr_vld = 1'b0;
        pulse_start();
        feed(16'h0003, 16'h0003, 8, 0);
        check("mrst_after_valid", sample_vld, 1);
        check("mrst_after_sample", sample, 8'hD0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
